// File: rtl/sr_latch_access_arbiter.sv
// Round-robin arbiter that shares one gated SR latch between NUM_REQ requesters and sequences its S/R/E inputs.
// Optional Q/Qbar readback check is enabled with `define SR_LATCH_VERIFY_EN.
module sr_latch_access_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned SETUP_LEN = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op,
  output logic [NUM_REQ-1:0] gnt,
  output logic               done,
  output logic               err,
  output logic               S,
  output logic               R,
  output logic               E,
  input  logic               Q,
  input  logic               Qbar
);

  localparam int unsigned MAX_LEN = (PULSE_LEN > SETUP_LEN) ? PULSE_LEN : SETUP_LEN;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);
  localparam int unsigned IW      = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      win_q, win_d;
  logic               op_q, op_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               s_q, s_d;
  logic               r_q, r_d;
  logic               e_q, e_d;
  logic               done_q, done_d;
  logic               err_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      cand_idx;
  int unsigned        cand;

  // First active requester at or after the round-robin pointer, wrapping at NUM_REQ-1.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand     = (32'(ptr_q) + i) % NUM_REQ;
      cand_idx = cand[IW-1:0];
      if (!pick_valid && req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    r_d     = r_q;
    e_d     = e_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        s_d   = 1'b0;
        r_d   = 1'b0;
        e_d   = 1'b0;
        if (pick_valid) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_LEN - 1);
          win_d   = pick_idx;
          op_d    = op[pick_idx];
          gnt_d   = NUM_REQ'(1) << pick_idx;
          s_d     = op[pick_idx];
          r_d     = ~op[pick_idx];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CW'(PULSE_LEN - 1);
          e_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        // S/R are released one cycle after E falls so the latch never sees E with S==R.
        state_d = DONE;
        s_d     = 1'b0;
        r_d     = 1'b0;
        done_d  = 1'b1;
`ifdef SR_LATCH_VERIFY_EN
        err_d = (Q != op_q) | (Qbar != ~op_q) | (Q == Qbar);
`endif
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        e_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= 1'b0;
      gnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      e_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      e_q     <= e_d;
      done_q  <= done_d;
    end
  end

`ifdef SR_LATCH_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_latch_fb;

  assign unused_latch_fb = ^{Q, Qbar, err_d};
  assign err             = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign done = done_q;
  assign S    = s_q;
  assign R    = r_q;
  assign E    = e_q;

endmodule

// File: tb/tb_sr_latch_access_arbiter.sv
// Scoreboard bench for sr_latch_access_arbiter driving a behavioural gated SR latch.
module tb_sr_latch_access_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] op;
  logic [N-1:0] gnt;
  logic         done, err, S, R, E, Q, Qbar;

  logic q_m   = 1'b0;
  bit   fault = 1'b0;

  typedef struct {
    logic [N-1:0] gnt;
    logic         q;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sr_latch_access_arbiter #(
    .NUM_REQ  (N),
    .PULSE_LEN(2),
    .SETUP_LEN(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .op   (op),
    .gnt  (gnt),
    .done (done),
    .err  (err),
    .S    (S),
    .R    (R),
    .E    (E),
    .Q    (Q),
    .Qbar (Qbar)
  );

  // Gated SR latch; with fault set, a set request leaves Q at 0.
  always @(S or R or E or fault) begin
    if (E) begin
      if (S && !R) q_m = !fault;
      else if (R && !S) q_m = 1'b0;
    end
  end
  assign Q    = q_m;
  assign Qbar = ~q_m;

  always @(negedge clk) begin
    checks++;
    if ((S && R) || (E && (S == R))) begin
      errors++;
      $display("FAIL latch_hazard: S=%b R=%b E=%b, required no S&R and no E with S==R", S, R, E);
    end
  end

  task automatic wait_done(input int start, output int lat, output int ehi, output bit ok);
    lat = start;
    ehi = 0;
    ok  = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      lat++;
      if (E) ehi++;
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    op    = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt, done, err, S, R, E} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b done=%b err=%b S=%b R=%b E=%b, required all 0",
                 gnt, done, err, S, R, E);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_ops();
    logic [1:0] ops;
    exp_t       ex;
    int         lat, ehi;
    bit         ok;
    ops = 2'b01;
    for (int k = 1; k >= 0; k--) begin
      req = 4'b0001;
      op  = {3'b000, ops[k]};
      sb.push_back('{gnt: 4'b0001, q: ops[k], err: 1'b0, lat: 6});
      @(negedge clk);
      checks++;
      if ({gnt, S, R, E} !== {4'b0001, ops[k], ~ops[k], 1'b0}) begin
        errors++;
        $display("FAIL setup_phase: gnt=%b S=%b R=%b E=%b, required gnt=0001 S=%b R=%b E=0",
                 gnt, S, R, E, ops[k], ~ops[k]);
      end
      wait_done(2, lat, ehi, ok);
      ex = sb.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL single_timeout: no done within 40 cycles, required done");
      end
      checks++;
      if ({gnt, Q, Qbar, err} !== {ex.gnt, ex.q, ~ex.q, ex.err}) begin
        errors++;
        $display("FAIL single_result: gnt=%b Q=%b Qbar=%b err=%b, required gnt=%b Q=%b Qbar=%b err=%b",
                 gnt, Q, Qbar, err, ex.gnt, ex.q, ~ex.q, ex.err);
      end
      checks++;
      if (lat !== ex.lat || ehi !== 2) begin
        errors++;
        $display("FAIL single_timing: latency=%0d E_high=%0d, required latency=%0d E_high=2",
                 lat, ehi, ex.lat);
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] ops;
    exp_t         ex;
    int           lat, ehi;
    bit           ok;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ops   = 4'b1010;
    req   = 4'b1111;
    op    = ops;
    for (int k = 0; k < 5; k++)
      sb.push_back('{gnt: 4'b0001 << (k % N), q: ops[k % N], err: 1'b0, lat: (k == 0) ? 6 : 7});
    for (int k = 0; k < 5; k++) begin
      wait_done(1, lat, ehi, ok);
      ex = sb.pop_front();
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rr_timeout: op %0d no done within 40 cycles, required done", k);
      end
      checks++;
      if ({gnt, Q, err} !== {ex.gnt, ex.q, ex.err} || lat !== ex.lat) begin
        errors++;
        $display("FAIL rr_order: op %0d gnt=%b Q=%b err=%b latency=%0d, required gnt=%b Q=%b err=%b latency=%0d",
                 k, gnt, Q, err, lat, ex.gnt, ex.q, ex.err, ex.lat);
      end
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    exp_t ex;
    int   lat, ehi;
    bit   ok, saw_done;
    req = 4'b0001;
    op  = 4'b0001;
    repeat (2) @(negedge clk);
    checks++;
    if (E !== 1'b1) begin
      errors++;
      $display("FAIL mid_pulse: E=%b, required 1", E);
    end
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    checks++;
    if ({gnt, done, S, R, E} !== '0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b done=%b S=%b R=%b E=%b, required all 0", gnt, done, S, R, E);
    end
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL aborted_done: done seen=%b, required 0", saw_done);
    end
    req = 4'b0100;
    op  = 4'b0000;
    sb.push_back('{gnt: 4'b0100, q: 1'b0, err: 1'b0, lat: 6});
    wait_done(1, lat, ehi, ok);
    ex = sb.pop_front();
    checks++;
    if (!ok || {gnt, Q, err} !== {ex.gnt, ex.q, ex.err} || lat !== ex.lat) begin
      errors++;
      $display("FAIL post_reset_serve: ok=%b gnt=%b Q=%b err=%b latency=%0d, required ok=1 gnt=%b Q=%b err=%b latency=%0d",
               ok, gnt, Q, err, lat, ex.gnt, ex.q, ex.err, ex.lat);
    end
    req = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef SR_LATCH_VERIFY_EN
  task automatic test_verify();
    exp_t ex;
    int   lat, ehi;
    bit   ok;
    for (int k = 0; k < 2; k++) begin
      fault = (k == 0);
      req   = 4'b0001;
      op    = 4'b0001;
      sb.push_back('{gnt: 4'b0001, q: (k == 0) ? 1'b0 : 1'b1, err: (k == 0), lat: 6});
      wait_done(1, lat, ehi, ok);
      ex = sb.pop_front();
      checks++;
      if (!ok || {gnt, Q, err} !== {ex.gnt, ex.q, ex.err}) begin
        errors++;
        $display("FAIL verify_err: fault=%0d ok=%b gnt=%b Q=%b err=%b, required ok=1 gnt=%b Q=%b err=%b",
                 k == 0, ok, gnt, Q, err, ex.gnt, ex.q, ex.err);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
        errors++;
        $display("FAIL verify_err_pulse: err=%b after done, required 0", err);
      end
    end
    fault = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    req   = '0;
    op    = '0;
    test_reset();
    test_single_ops();
    test_round_robin();
    test_reset_mid_op();
`ifdef SR_LATCH_VERIFY_EN
    test_verify();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
